instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller for the single-issue accumulator-style core.
- Owns the program counter and the instruction register.
- Gates the combinational control decoder's strobes (RegWrite, MemWrite, Branch) so each fires exactly once per instruction.
- Runs the data-memory req/ready handshake and resolves the conditional branches (opcodes 1011 eq, 1100 ge, 1101 le). Sits between instruction ROM, control decoder, ALU flags and data memory.

Parameters:
- PCW, 10, program counter width.
- IW, 9, instruction width; opcode = instr[IW-1:IW-4].
- MEM_TIMEOUT, 15, max cycles waiting for dmem_ready before fault.

Ports:
- Clk  input  1  clock, rising edge
- Reset_n  input  1  asynchronous active-low reset
- start  input  1  begin execution at PC 0 (sampled in IDLE only)
- prog_len  input  PCW  PC value at which the program is finished
- imem_rdata  input  IW  instruction ROM data, valid one cycle after imem_addr
- imem_addr  output  PCW  = pc
- instr  output  IW  instruction register contents (feeds decoder)
- dec_branch, dec_memwrite, dec_memtoreg, dec_regwrite  input  1 each  control decoder outputs for instr
- zero_flg, less_flg  input  1 each  ALU flags from the most recent compare
- branch_target  input  PCW  target from branch LUT, indexed by instr
- reg_we  output  1  register-file write strobe (one cycle)
- flag_we  output  1  latch ALU flags (one cycle, EXEC of non-branch, non-memory ops)
- dmem_req  output  1  data-memory request
- dmem_we  output  1  write qualifier, valid with dmem_req
- dmem_ready  input  1  data memory completion
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  high in DONE
- fault  output  1  sticky; set on memory timeout
- instr_count  output  16  retired instructions, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE. Encoding is free.
- Reset (async, Reset_n=0): state=IDLE, pc=0, instr=0, instr_count=0, fault=0; all strobes, dmem_req, busy and done are 0.
- IDLE: if start, then pc<=0, instr_count<=0, fault<=0, go FETCH. If prog_len==0, go directly to DONE.
- FETCH (1 cycle): imem_addr=pc; go DECODE.
- DECODE: instr<=imem_rdata. The decoder output becomes valid in EXEC.
- EXEC: branching depends on the decoder strobes.
  - dec_branch=1: taken = (op==1011 & zero_flg) | (op==1100 & !less_flg) | (op==1101 & (less_flg|zero_flg)). Any other opcode with dec_branch is not taken. Go WB.
  - dec_memwrite or dec_memtoreg: go MEM.
  - otherwise: flag_we=1 only if op==1001 (compare); go WB.
- MEM: dmem_req=1, dmem_we=dec_memwrite, held until dmem_ready sampled high.
  - The wait counter starts at 0 on MEM entry.
  - If dmem_ready arrives in the same cycle the counter reaches MEM_TIMEOUT, treat it as success.
  - If the counter reaches MEM_TIMEOUT first, set fault, drop dmem_req and go DONE without retiring the instruction.
  - On dmem_ready, go WB.
- WB (1 cycle): reg_we = dec_regwrite & !dec_memwrite & !dec_branch. instr_count increments (saturates at FFFF).
  - Next pc = branch_target if taken, else pc+1. The increment wraps modulo 2^PCW.
  - If next pc >= prog_len, go DONE; else go FETCH.
- DONE: done=1. start=1 restarts, with the same effect as start in IDLE.
- Latency per instruction: ALU/branch ops take 4 cycles (FETCH, DECODE, EXEC, WB). Memory ops take 4 + N cycles, where N≥1 is the number of MEM cycles up to and including the one where dmem_ready is sampled.
- Only one of reg_we, dmem_req and flag_we is ever high in any cycle.
- start outside IDLE/DONE is ignored.
- Reset_n asserted mid-MEM drops dmem_req asynchronously. No write strobe may glitch.
- The branch decision uses flags as held in EXEC. Flags are not updated by branch instructions.

Test Plan:
- Reset then start with prog_len=3; ROM holds 0111 add, 0001 or, 0101 sub → done after exactly 12 cycles post-start, 3 reg_we pulses, instr_count=3, pc=3.
- Compare (1001) with zero_flg=1, then 1011 with branch_target=0x05, prog_len=8 → flag_we one pulse; pc jumps 1→5; no reg_we on the branch.
- 1100 with less_flg=1 → not taken, pc+1. 1101 with less_flg=0, zero_flg=1 → taken.
- Store (1111), dmem_ready after 3 cycles → dmem_req high 3 cycles with dmem_we=1, then WB with reg_we=0. Load (1000) → dmem_we=0, reg_we pulse in WB.
- Store with dmem_ready never asserted → fault=1 after MEM_TIMEOUT cycles, dmem_req drops, done=1, instr_count unchanged.
- Reset_n pulled low during MEM → immediate dmem_req=0, busy=0, pc=0. After release, start reruns the program from PC 0 with correct counts.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the accumulator core.
// Owns PC and instruction register. It fires each decoder strobe once per
// instruction, runs the data-memory handshake and resolves conditional branches.
module instr_sequencer #(
  parameter int PCW         = 10,
  parameter int IW          = 9,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [PCW-1:0] prog_len_i,
  input  logic [IW-1:0]  imem_rdata_i,
  output logic [PCW-1:0] imem_addr_o,
  output logic [IW-1:0]  instr_o,
  input  logic           dec_branch_i,
  input  logic           dec_memwrite_i,
  input  logic           dec_memtoreg_i,
  input  logic           dec_regwrite_i,
  input  logic           zero_flg_i,
  input  logic           less_flg_i,
  input  logic [PCW-1:0] branch_target_i,
  output logic           reg_we_o,
  output logic           flag_we_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  input  logic           dmem_ready_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           fault_o,
  output logic [15:0]    instr_count_o
);

  localparam int            CW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);
  localparam logic [3:0]    OP_CMP  = 4'b1001;
  localparam logic [3:0]    OP_BEQ  = 4'b1011;
  localparam logic [3:0]    OP_BGE  = 4'b1100;
  localparam logic [3:0]    OP_BLE  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_e;

  state_e         state_q;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  instr_q;
  logic [15:0]    count_q;
  logic [CW-1:0]  wait_q;
  logic           taken_q, fault_q, busy_q, done_q;
  logic           reg_we_q, dmem_req_q, dmem_we_q;
  logic [3:0]     op;
  logic           br_taken;

  assign op = instr_q[IW-1:IW-4];

  // Branch condition from the flags as presented during EXEC
  assign br_taken = ((op == OP_BEQ) & zero_flg_i)
                  | ((op == OP_BGE) & ~less_flg_i)
                  | ((op == OP_BLE) & (less_flg_i | zero_flg_i));

  // Next PC used in WB; the increment wraps at 2^PCW
  assign pc_d = taken_q ? branch_target_i : pc_q + PCW'(1);

  // Main FSM; strobes, busy and done are registered on state entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      taken_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reg_we_q   <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            pc_q    <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
            if (prog_len_i == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          instr_q <= imem_rdata_i;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (dec_branch_i) begin
            taken_q <= br_taken;
            state_q <= S_WB;
          end else if (dec_memwrite_i | dec_memtoreg_i) begin
            taken_q    <= 1'b0;
            wait_q     <= '0;
            dmem_req_q <= 1'b1;
            dmem_we_q  <= dec_memwrite_i;
            state_q    <= S_MEM;
          end else begin
            taken_q  <= 1'b0;
            reg_we_q <= dec_regwrite_i;
            state_q  <= S_WB;
          end
        end
        S_MEM: begin
          // Ready wins over timeout when both land in the same cycle
          if (dmem_ready_i) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= dec_regwrite_i & ~dec_memwrite_i;
            state_q    <= S_WB;
          end else if (wait_q == TIMEOUT) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            fault_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        S_WB: begin
          pc_q <= pc_d;
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
          if (pc_d >= prog_len_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // flag_we follows the decoder, which settles from instr_q held through EXEC
  assign flag_we_o = (state_q == S_EXEC) & ~dec_branch_i & ~dec_memwrite_i
                   & ~dec_memtoreg_i & (op == OP_CMP);

  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign reg_we_o      = reg_we_q;
  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level reference model
// predicts every strobe event and the final state; a monitor checks them.
module tb_instr_sequencer;
  localparam int PCW = 10, IW = 9, MEM_TIMEOUT = 15;
  localparam int K_FLAG = 0, K_MEM = 1, K_REG = 2, K_DONE = 3;

  logic           clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [PCW-1:0] prog_len_i = '0;
  logic [IW-1:0]  imem_rdata_i;
  logic [PCW-1:0] imem_addr_o, branch_target_i;
  logic [IW-1:0]  instr_o;
  logic           dec_branch_i, dec_memwrite_i, dec_memtoreg_i, dec_regwrite_i;
  logic           zero_flg_i, less_flg_i, dmem_ready_i;
  logic           reg_we_o, flag_we_o, dmem_req_o, dmem_we_o, busy_o, done_o, fault_o;
  logic [15:0]    instr_count_o;

  instr_sequencer #(.PCW(PCW), .IW(IW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .prog_len_i(prog_len_i),
    .imem_rdata_i(imem_rdata_i), .imem_addr_o(imem_addr_o), .instr_o(instr_o),
    .dec_branch_i(dec_branch_i), .dec_memwrite_i(dec_memwrite_i),
    .dec_memtoreg_i(dec_memtoreg_i), .dec_regwrite_i(dec_regwrite_i),
    .zero_flg_i(zero_flg_i), .less_flg_i(less_flg_i), .branch_target_i(branch_target_i),
    .reg_we_o(reg_we_o), .flag_we_o(flag_we_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i), .busy_o(busy_o),
    .done_o(done_o), .fault_o(fault_o), .instr_count_o(instr_count_o));

  always #5 clk_i = ~clk_i;

  // Environment tables: ROM, per-PC flags and memory latency (0 = never ready),
  // branch LUT indexed by the low instruction bits.
  logic [IW-1:0] rom [0:1023];
  bit            zf  [0:1023];
  bit            lf  [0:1023];
  int            lat [0:1023];
  int            tgt [0:31];

  typedef struct { int kind; int cyc; int pc; int we; int cnt; int flt; } ev_t;
  ev_t exp_q[$];

  int vecs = 0, errs = 0;
  int cyc = 100000;
  int mcnt = 0;
  bit go = 0, mon_en = 1, done_prev = 0;

  function automatic bit is_br(input logic [3:0] op);
    return op == 4'b1010 || op == 4'b1011 || op == 4'b1100 || op == 4'b1101;
  endfunction
  // Decoder: compare and 1110 do not write; store and branches do request it,
  // so the sequencer's gating is exercised.
  function automatic bit dec_rw(input logic [3:0] op);
    return !(op == 4'b1001 || op == 4'b1110);
  endfunction

  // ROM with one cycle read latency, decoder, flags, branch LUT, memory
  always @(posedge clk_i) imem_rdata_i <= rom[imem_addr_o];
  always_comb begin
    dec_branch_i    = is_br(instr_o[8:5]);
    dec_memwrite_i  = instr_o[8:5] == 4'b1111;
    dec_memtoreg_i  = instr_o[8:5] == 4'b1000;
    dec_regwrite_i  = dec_rw(instr_o[8:5]);
    zero_flg_i      = zf[imem_addr_o];
    less_flg_i      = lf[imem_addr_o];
    branch_target_i = PCW'(tgt[instr_o[4:0]]);
    dmem_ready_i    = dmem_req_o && lat[imem_addr_o] != 0 && mcnt == lat[imem_addr_o] - 1;
  end
  always @(posedge clk_i) mcnt <= dmem_req_o ? mcnt + 1 : 0;
  always @(posedge clk_i) cyc  <= go ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe cycle or DONE arrival pops one expected event
  always @(negedge clk_i) begin
    int ns, kind;
    bit dn;
    ev_t e;
    ns = int'(reg_we_o) + int'(flag_we_o) + int'(dmem_req_o);
    dn = done_o && (!done_prev || cyc == 0);
    if (mon_en && rst_ni && (ns > 0 || dn)) begin
      if (ns > 1) chk("strobe_onehot", ns, 1);
      kind = dn ? K_DONE : reg_we_o ? K_REG : flag_we_o ? K_FLAG : K_MEM;
      if (exp_q.size() == 0) chk("unexpected_event", kind, -1);
      else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_pc", int'(imem_addr_o), e.pc);
        if (kind == K_MEM) chk("dmem_we", int'(dmem_we_o), e.we);
        if (kind == K_DONE) begin
          chk("instr_count", int'(instr_count_o), e.cnt);
          chk("fault", int'(fault_o), e.flt);
          chk("busy_done", int'(busy_o), 0);
        end else chk("busy_run", int'(busy_o), 1);
      end
    end
    done_prev <= done_o;
  end

  // Reference model: walk the program instruction by instruction and list the
  // cycle (counted from the start edge) of each observable event.
  task automatic model(input int plen, output bit ok);
    ev_t q[$];
    int t = 0, pc = 0, cnt = 0, wb, npc;
    logic [3:0] op;
    bit taken;
    ok = 0;
    if (plen == 0) begin
      exp_q.push_back('{K_DONE, 0, 0, 0, 0, 0});
      ok = 1;
      return;
    end
    for (int g = 0; g < 150; g++) begin
      op = rom[pc][8:5];
      taken = 0;
      if (is_br(op)) begin
        taken = (op == 4'b1011 && zf[pc]) || (op == 4'b1100 && !lf[pc]) ||
                (op == 4'b1101 && (lf[pc] || zf[pc]));
        wb = t + 3;
      end else if (op == 4'b1111 || op == 4'b1000) begin
        if (lat[pc] == 0) begin
          for (int i = 0; i <= MEM_TIMEOUT; i++)
            q.push_back('{K_MEM, t + 3 + i, pc, int'(op == 4'b1111), 0, 0});
          q.push_back('{K_DONE, t + 4 + MEM_TIMEOUT, pc, 0, cnt, 1});
          foreach (q[i]) exp_q.push_back(q[i]);
          ok = 1;
          return;
        end
        for (int i = 0; i < lat[pc]; i++)
          q.push_back('{K_MEM, t + 3 + i, pc, int'(op == 4'b1111), 0, 0});
        wb = t + 3 + lat[pc];
        if (op == 4'b1000) q.push_back('{K_REG, wb, pc, 0, 0, 0});
      end else begin
        if (op == 4'b1001) q.push_back('{K_FLAG, t + 2, pc, 0, 0, 0});
        wb = t + 3;
        if (dec_rw(op)) q.push_back('{K_REG, wb, pc, 0, 0, 0});
      end
      cnt++;
      npc = taken ? tgt[rom[pc][4:0]] : (pc + 1) % 1024;
      t = wb + 1;
      pc = npc;
      if (pc >= plen) begin
        q.push_back('{K_DONE, t, pc, 0, cnt, 0});
        foreach (q[i]) exp_q.push_back(q[i]);
        ok = 1;
        return;
      end
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = '0; zf[i] = 0; lf[i] = 0; lat[i] = 1;
    end
    for (int i = 0; i < 32; i++) tgt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  // Issue one program: predict, start, wait (bounded) for done, drain check.
  // spur >= 0 pulses start at that cycle while busy; it must be ignored.
  task automatic run(input int plen, input int spur);
    bit ok, seen;
    model(plen, ok);
    if (!ok) return;
    prog_len_i = PCW'(plen);
    @(negedge clk_i);
    start_i = 1'b1; go = 1;
    @(negedge clk_i);
    start_i = 1'b0; go = 0;
    seen = 0;
    for (int k = 0; k < 4000; k++) begin
      if (done_o) begin seen = 1; break; end
      start_i = (k == spur);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    if (!seen) begin
      chk("done_wait_timeout", 0, 1);
      do_reset();
      return;
    end
    @(negedge clk_i);
    chk("events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int plen;
    bit seen;
    clear_tables();
    #1;
    chk("rst_state_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pc", int'(imem_addr_o), 0);
    chk("rst_instr", int'(instr_o), 0);
    chk("rst_count", int'(instr_count_o), 0);
    chk("rst_fault", int'(fault_o), 0);
    chk("rst_strobes", int'({reg_we_o, flag_we_o, dmem_req_o}), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // add, or, sub: 12 cycles, 3 reg_we, with an ignored mid-run start
    rom[0] = {4'b0111, 5'd0}; rom[1] = {4'b0001, 5'd0}; rom[2] = {4'b0101, 5'd0};
    run(3, 5);

    // compare then taken beq 1 -> 5
    clear_tables();
    rom[0] = {4'b1001, 5'd0}; rom[1] = {4'b1011, 5'd3}; tgt[3] = 5; zf[1] = 1;
    run(8, -1);

    // bge with less=1 not taken, ble with zero=1 taken, 1010 never taken
    clear_tables();
    rom[0] = {4'b1100, 5'd1}; lf[0] = 1; tgt[1] = 7;
    rom[1] = {4'b1101, 5'd2}; zf[1] = 1; tgt[2] = 4;
    rom[4] = {4'b1010, 5'd1}; zf[4] = 1;
    run(6, -1);

    // store (3 MEM cycles), load (1), load at the timeout boundary (16)
    clear_tables();
    rom[0] = {4'b1111, 5'd0}; lat[0] = 3;
    rom[1] = {4'b1000, 5'd0}; lat[1] = 1;
    rom[2] = {4'b1000, 5'd0}; lat[2] = MEM_TIMEOUT + 1;
    run(3, -1);

    // store never acknowledged: fault, no retire
    clear_tables();
    rom[1] = {4'b1111, 5'd0}; lat[1] = 0;
    run(4, -1);

    // empty program, restarted from DONE; fault cleared by the restart
    run(0, -1);

    // reset asserted mid-MEM, then a clean rerun
    clear_tables();
    rom[1] = {4'b1111, 5'd0}; lat[1] = 0;
    mon_en = 0;
    prog_len_i = PCW'(4);
    @(negedge clk_i); start_i = 1'b1; go = 1;
    @(negedge clk_i); start_i = 1'b0; go = 0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (dmem_req_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    chk("mem_entered", int'(seen), 1);
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_req", int'(dmem_req_o), 0);
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_pc", int'(imem_addr_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete();
    mon_en = 1;
    lat[1] = 2;
    run(4, -1);

    // randomized programs
    for (int r = 0; r < 30; r++) begin
      clear_tables();
      plen = $urandom_range(1, 20);
      for (int i = 0; i < plen; i++) begin
        rom[i] = {4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
        zf[i]  = 1'($urandom_range(0, 1));
        lf[i]  = 1'($urandom_range(0, 1));
        lat[i] = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, MEM_TIMEOUT + 1);
      end
      for (int i = 0; i < 32; i++) tgt[i] = $urandom_range(0, plen + 2);
      run(plen, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
